ps2_host_tx: RTL and testbench

- Host-to-device PS/2 command transmitter. Sends one command byte (reset, enable scanning, set LEDs, scan-code set select) from the FPGA to the keyboard.
- Sits beside keyboard_decoder. The top level owns the PS2_CLK/PS2_DAT tristates and merges this block's pull-low enables with the decoder's.
- Implements inhibit, request-to-send, device-clocked bit shifting, ack check and timeouts.
- Reports per-command completion and error code to the keyboard init sequencer.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 53 +++++
 rtl/ps2_host_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command bytes and helpers for the host transmitter and the keyboard decoder
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_START,
        ST_SEND,
        ST_WAIT_IDLE,
        ST_FIN
    } tx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_START_TO = 2'd1,
        ERR_PKT_TO   = 2'd2,
        ERR_NO_ACK   = 2'd3
    } err_code_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] CMD_SCAN_SET = 8'hF0;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes raw PS/2 clock/data pins and flags maskable clock falling edges
//   i_clk, i_rst_n   system clock, async active-low reset
//   i_ps2_clk/dat    raw pin levels
//   i_mask           suppress falling-edge reports (e.g. while we drive the clock ourselves)
//   o_clk_s/o_dat_s  synchronized pin levels
//   o_clk_fall       one-cycle pulse, SYNC_STAGES+1 cycles after the pin falls
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    input  logic i_mask,
    output logic o_clk_s,
    output logic o_dat_s,
    output logic o_clk_fall
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d    = clk_sync_q;
        dat_sync_d    = dat_sync_q;
        clk_sync_d[0] = i_ps2_clk;
        dat_sync_d[0] = i_ps2_dat;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_d[i] = clk_sync_q[i-1];
            dat_sync_d[i] = dat_sync_q[i-1];
        end
        clk_prev_d = o_clk_s;
    end

    // Reset to 0 so a line is treated as busy until it has been seen high after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign o_clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign o_dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign o_clk_fall = clk_prev_q & ~o_clk_s & ~i_mask;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with inhibit, request-to-send, ack check and timeouts
//   i_clk_100k, i_rst_n        system clock (100 kHz), async active-low reset
//   i_valid/i_data/o_ready     command byte handshake, byte sent LSB first
//   i_ps2_clk/i_ps2_dat        raw pin levels
//   o_ps2_clk_oe/o_ps2_dat_oe  1 = pull the line low, 0 = release
//   o_busy                     transaction in progress
//   o_done/o_err_code          end-of-transaction pulse and its result (code held until next o_done)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 12,
    parameter int START_TO_CYC = 1500,
    parameter int PKT_TO_CYC   = 200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk_100k,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err_code
);

    localparam int TMR_MAX = (START_TO_CYC > PKT_TO_CYC) ? START_TO_CYC : PKT_TO_CYC;
    localparam int TW      = $clog2(TMR_MAX) + 1;
    localparam int MW      = $clog2(SYNC_STAGES + 2);

    tx_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d, timer_inc;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    err_code_e       err_q, err_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic            clk_s, dat_s, clk_fall, dat_oe;

    // The clock is only ever pulled in INHIBIT/REQ; kept apart from the FSM block so the
    // edge mask that depends on it never feeds back into itself.
    assign o_ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign o_ps2_dat_oe = dat_oe;
    assign o_ready      = (state_q == ST_IDLE) && clk_s && dat_s;
    assign o_busy       = state_q != ST_IDLE;
    assign o_done       = state_q == ST_FIN;
    assign o_err_code   = err_q;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk_100k),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_dat  (i_ps2_dat),
        .i_mask     (o_ps2_clk_oe || (mask_q != '0)),
        .o_clk_s    (clk_s),
        .o_dat_s    (dat_s),
        .o_clk_fall (clk_fall)
    );

    // Our own clock pull and its release ripple through the synchronizer; ignore edges
    // until that has flushed.
    assign mask_d    = o_ps2_clk_oe ? MW'(SYNC_STAGES + 1) : (mask_q != '0) ? mask_q - 1'b1 : mask_q;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        dat_oe    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (i_valid && o_ready) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = {1'b1, odd_parity(i_data), i_data};
                    bit_cnt_d = '0;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYC - 1)) begin
                    state_d = ST_REQ;
                    timer_d = '0;
                end
            end
            ST_REQ: begin
                dat_oe  = 1'b1;
                state_d = ST_WAIT_START;
                timer_d = '0;
            end
            ST_WAIT_START: begin
                dat_oe = 1'b1;
                if (clk_fall) begin
                    state_d   = ST_SEND;
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                end else if (timer_q >= TW'(START_TO_CYC - 1)) begin
                    state_d = ST_FIN;
                    err_d   = ERR_START_TO;
                    dat_oe  = 1'b0;
                end
            end
            ST_SEND: begin
                // shift_q[0] is the bit on the wire; ones are sent by releasing the line.
                dat_oe = ~shift_q[0];
                if (clk_fall) begin
                    if (bit_cnt_q == 4'd10) begin
                        state_d = dat_s ? ST_FIN : ST_WAIT_IDLE;
                        if (dat_s) err_d = ERR_NO_ACK;
                        dat_oe = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = {1'b1, shift_q[9:1]};
                    end
                end else if (timer_q >= TW'(PKT_TO_CYC - 1)) begin
                    state_d = ST_FIN;
                    err_d   = ERR_PKT_TO;
                    dat_oe  = 1'b0;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    state_d = ST_FIN;
                    err_d   = ERR_NONE;
                end else if (timer_q >= TW'(PKT_TO_CYC - 1)) begin
                    state_d = ST_FIN;
                    err_d   = ERR_PKT_TO;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '1;
            err_q     <= ERR_NONE;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side model and cycle-level reference for the PS/2 host transmitter
module tb_ps2_host_tx;

    localparam int INH = 12;
    localparam int STO = 1500;
    localparam int PTO = 200;
    localparam int SS  = 2;

    localparam int M_ACK   = 0;
    localparam int M_NOCLK = 1;
    localparam int M_NOACK = 2;
    localparam int M_STOP4 = 3;
    localparam int M_RESET = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, clk_oe, dat_oe, busy, done;
    logic [1:0] err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk, ps2_dat;
    int         tests = 0;
    int         fails = 0;

    // Open-drain bus: low if either side pulls it.
    assign ps2_clk = ~(clk_oe | dev_clk_low);
    assign ps2_dat = ~(dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYC(INH), .START_TO_CYC(STO), .PKT_TO_CYC(PTO), .SYNC_STAGES(SS)
    ) dut (
        .i_clk_100k   (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .i_data       (data),
        .o_ready      (ready),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_dat_oe (dat_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_err_code   (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fe(input int f1, input int h, input int i);
        return f1 + 2 * h * (i - 1);
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, ready, 1'b1);
    endtask

    // Runs one transaction. Relative cycle t=0 is the cycle right after the accepting edge.
    // Device falling edge i drops the pin at t = f1 + 2h(i-1); the host reacts SS+1 cycles later.
    task automatic run_txn(input logic [7:0] d, input int mode, input int dly, input int h,
                           output logic [9:0] seen, output int inh_cnt,
                           output int done_obs, output int rel_obs);
        logic [9:0] frame;
        int n_edges, f1, f11, done_t, t_abort, exp_err, k;
        logic e_dat;
        frame    = {1'b1, ($countones(d) % 2 == 0), d};
        f1       = INH + 1 + dly;
        f11      = fe(f1, h, 11);
        n_edges  = (mode == M_NOCLK) ? 0 : (mode == M_STOP4) ? 4 : (mode == M_RESET) ? 5 : 11;
        t_abort  = fe(f1, h, 5) + SS + 1;
        done_t   = (mode == M_NOCLK) ? INH + 1 + STO :
                   (mode == M_STOP4) ? f1 + SS + 1 + PTO :
                   (mode == M_NOACK) ? f11 + SS + 1 :
                   (mode == M_ACK)   ? f11 + h + SS + 1 : t_abort + 1000;
        exp_err  = (mode == M_NOCLK) ? 1 : (mode == M_STOP4) ? 2 : (mode == M_NOACK) ? 3 : 0;
        seen     = '0;
        inh_cnt  = 0;
        done_obs = -1;
        rel_obs  = -1;
        wait_ready("ready_before_txn");
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int t = 0; t <= done_t + 1; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 1; i <= 10; i++)
                if (i <= n_edges && t == fe(f1, h, i) + h) seen[i-1] = ps2_dat;
            dev_clk_low = 1'b0;
            for (int i = 1; i <= n_edges; i++)
                if (t >= fe(f1, h, i) && t < fe(f1, h, i) + h) dev_clk_low = 1'b1;
            dev_dat_low = (mode == M_ACK) && t >= f11 - 1 && t < f11 + h;
            @(negedge clk);
            k = 0;
            for (int i = 1; i <= n_edges; i++)
                if (fe(f1, h, i) + SS + 1 <= t) k++;
            e_dat = (t < INH || t > done_t) ? 1'b0 : (k == 0) ? 1'b1 : (k <= 10) ? ~frame[k-1] : 1'b0;
            if ((mode == M_NOCLK || mode == M_NOACK || mode == M_STOP4) && t >= done_t - 1) e_dat = 1'b0;
            if (t == done_t) e_dat = 1'b0;
            chk("clk_oe", clk_oe, t <= INH);
            chk("dat_oe", dat_oe, e_dat);
            chk("busy", busy, t <= done_t);
            chk("done", done, t == done_t);
            if (t == done_t) chk("err_code", err, exp_err);
            if (clk_oe && !dat_oe) inh_cnt++;
            if (done && done_obs < 0) done_obs = t;
            if (!clk_oe && t > 0 && rel_obs < 0) rel_obs = t;
            if (mode == M_RESET && t == t_abort) begin
                dev_clk_low = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("rst_clk_oe", clk_oe, 1'b0);
                chk("rst_dat_oe", dat_oe, 1'b0);
                chk("rst_busy", busy, 1'b0);
                break;
            end
        end
        if (mode != M_RESET) begin
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            @(negedge clk);
            chk("err_hold", err, exp_err);
            chk("done_after", done, 1'b0);
        end
    endtask

    initial begin
        logic [9:0] seen;
        int inh, dobs, robs, mode, dly, h;
        logic [7:0] d;
        #2;
        chk("reset_clk_oe", clk_oe, 1'b0);
        chk("reset_dat_oe", dat_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 2'd0);
        chk("reset_ready", ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_txn(8'hF4, M_ACK, 3, 4, seen, inh, dobs, robs);
        chk("t1_bits", seen, 10'h2F4);
        chk("t1_inhibit_cycles", inh, 12);
        wait_ready("t1_ready_back");

        run_txn(8'hED, M_ACK, 5, 4, seen, inh, dobs, robs);
        chk("t2_parity", seen[8], 1'b1);
        chk("t2_bits", seen, 10'h3ED);

        run_txn(8'hFF, M_NOCLK, 4, 4, seen, inh, dobs, robs);
        chk("t3_start_to_dist", dobs - robs, 1500);
        chk("t3_err", err, 2'd1);

        run_txn(8'hF0, M_NOACK, 2, 4, seen, inh, dobs, robs);
        chk("t4_err", err, 2'd3);
        chk("t4_oe", {clk_oe, dat_oe}, 2'b00);

        run_txn(8'hF4, M_STOP4, 6, 4, seen, inh, dobs, robs);
        chk("t5_pkt_to_dist", dobs - (INH + 1 + 6 + SS + 1), 200);
        chk("t5_err", err, 2'd2);

        run_txn(8'hF0, M_RESET, 3, 4, seen, inh, dobs, robs);
        repeat (2) @(negedge clk) chk("rst_hold_ready", ready, 1'b0);
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;
        repeat (20) begin
            @(negedge clk);
            chk("t6_ready_low", ready, 1'b0);
            chk("t6_no_inhibit", clk_oe, 1'b0);
            chk("t6_not_busy", busy, 1'b0);
        end
        chk("t6_err", err, 2'd0);
        valid = 1'b0;
        dev_clk_low = 1'b0;
        wait_ready("t6_ready_back");

        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            dly  = int'($urandom_range(2, 10));
            h    = int'($urandom_range(4, 6));
            run_txn(d, mode, dly, h, seen, inh, dobs, robs);
            if (mode == M_ACK || mode == M_NOACK)
                chk("rand_bits", seen, {1'b1, ($countones(d) % 2 == 0), d});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
